// File: rtl/mul_seq_unit.sv
// mul_seq_unit: multi-cycle unsigned NxN->2N shift-add multiplier.
// The N-bit adder is an external instance; this block drives its operands and consumes its sum/carry.
module mul_seq_unit #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplier,
   output logic [N-1:0]   add_a,
   output logic [N-1:0]   add_b,
   input  logic [N-1:0]   add_sum,
   input  logic           add_cout,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] cnt_last = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  mcand_q, mcand_d;
   logic [N-1:0]  acc_hi_q, acc_hi_d;
   logic [N-1:0]  acc_lo_q, acc_lo_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: if (start) begin
            mcand_d  = mcand;
            acc_hi_d = '0;
            acc_lo_d = mplier;
            cnt_d    = '0;
            state_d  = RUN;
         end
         // the adder carry becomes the new top bit, so no product bit is lost on the shift
         RUN: begin
            {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[N-1:1]};
            cnt_d                = cnt_q + 1'b1;
            state_d              = (cnt_q == cnt_last) ? DONE : RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
      end
   end

   assign add_a   = acc_hi_q;
   assign add_b   = acc_lo_q[0] ? mcand_q : '0;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign product = {acc_hi_q, acc_lo_q};
endmodule
